// File: rtl/exa_crosb_output_vc_arbiter.sv
// Output-port VC arbiter: grants one requesting input per packet and holds it until the last flit,
// while tracking per-output-VC FIFO credits and exporting a credit-available vector.
module exa_crosb_output_vc_arbiter #(
    parameter int input_num  = 4,
    parameter int prio_num   = 2,
    parameter int vc_num     = 2,
    parameter int credit_num = 8,
    localparam int vc_total  = prio_num * vc_num,
    localparam int logVcPrio = (vc_total > 1) ? $clog2(vc_total) : 1,
    localparam int logInput  = (input_num > 1) ? $clog2(input_num) : 1,
    localparam int logCredit = $clog2(credit_num + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [input_num*vc_total-1:0] i_request,
    input  logic [input_num-1:0]          i_valid,
    input  logic [input_num-1:0]          i_last,
    input  logic [vc_total-1:0]           i_credit_return,
    output logic [input_num-1:0]          o_grant,
    output logic [logVcPrio-1:0]          o_grant_vc,
    output logic                          o_ready,
    output logic                          o_write_en,
    output logic [logVcPrio-1:0]          o_write_vc,
    output logic [vc_total-1:0]           o_credits,
    output logic                          o_credit_err
);
    localparam int logVc   = (vc_num > 1) ? $clog2(vc_num) : 1;
    localparam int logPrio = (prio_num > 1) ? $clog2(prio_num) : 1;

    typedef enum logic {IDLE, GRANTED} state_t;
    state_t state, state_nxt;

    logic [logInput-1:0]  gnt_in, in_ptr, sel_in;
    logic [logVcPrio-1:0] gnt_vc, sel_vc;
    logic [logVc-1:0]     vc_ptr [prio_num];
    logic [logCredit-1:0] cnt [vc_total];
    logic [logCredit-1:0] cnt_nxt [vc_total];
    logic [vc_total-1:0]  vc_req, vc_elig;
    logic                 sel_found, pkt_done, err_set;
    logic [logPrio-1:0]   gnt_prio;
    logic [logVc-1:0]     gnt_sub;

    always_comb begin
        vc_req  = '0;
        vc_elig = '0;
        for (int i = 0; i < input_num; i++)
            vc_req = vc_req | i_request[i*vc_total +: vc_total];
        for (int k = 0; k < vc_total; k++)
            vc_elig[k] = vc_req[k] && (cnt[k] != '0);
    end

    // Highest priority wins; within it, rotate starting just after the last-served VC.
    always_comb begin
        int v;
        sel_found = 1'b0;
        sel_vc    = '0;
        v         = 0;
        for (int p = prio_num - 1; p >= 0; p--) begin
            for (int o = 1; o <= vc_num; o++) begin
                v = (int'(vc_ptr[p]) + o) % vc_num;
                if (!sel_found && vc_elig[p*vc_num + v]) begin
                    sel_found = 1'b1;
                    sel_vc    = logVcPrio'(p*vc_num + v);
                end
            end
        end
    end

    always_comb begin
        int   n;
        logic hit;
        hit    = 1'b0;
        sel_in = '0;
        n      = 0;
        for (int o = 1; o <= input_num; o++) begin
            n = (int'(in_ptr) + o) % input_num;
            if (!hit && i_request[n*vc_total + int'(sel_vc)]) begin
                hit    = 1'b1;
                sel_in = logInput'(n);
            end
        end
    end

    assign gnt_prio   = logPrio'(int'(gnt_vc) / vc_num);
    assign gnt_sub    = logVc'(int'(gnt_vc) % vc_num);
    assign o_grant_vc = gnt_vc;
    assign o_write_vc = gnt_vc;
    assign o_ready    = (state == GRANTED) && (cnt[gnt_vc] != '0);
    assign o_write_en = o_ready && i_valid[gnt_in];
    assign pkt_done   = o_write_en && i_last[gnt_in];

    always_comb begin
        o_grant = '0;
        if (state == GRANTED) o_grant[gnt_in] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_found) state_nxt = GRANTED;
            GRANTED: if (pkt_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A consume and a return on the same VC cancel; a return to a full counter is an error.
    always_comb begin
        logic consume;
        consume = 1'b0;
        err_set = 1'b0;
        for (int k = 0; k < vc_total; k++) begin
            consume    = o_write_en && (int'(gnt_vc) == k);
            cnt_nxt[k] = cnt[k];
            if (consume && !i_credit_return[k])
                cnt_nxt[k] = cnt[k] - 1'b1;
            else if (!consume && i_credit_return[k]) begin
                if (cnt[k] == logCredit'(credit_num)) err_set = 1'b1;
                else cnt_nxt[k] = cnt[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            gnt_in       <= '0;
            gnt_vc       <= '0;
            in_ptr       <= '0;
            o_credits    <= '1;
            o_credit_err <= 1'b0;
            for (int k = 0; k < vc_total; k++) cnt[k] <= logCredit'(credit_num);
            for (int p = 0; p < prio_num; p++) vc_ptr[p] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && sel_found) begin
                gnt_in <= sel_in;
                gnt_vc <= sel_vc;
            end
            if (pkt_done) begin
                in_ptr           <= gnt_in;
                vc_ptr[gnt_prio] <= gnt_sub;
            end
            for (int k = 0; k < vc_total; k++) begin
                cnt[k]       <= cnt_nxt[k];
                o_credits[k] <= (cnt_nxt[k] != '0);
            end
            if (err_set) o_credit_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_exa_crosb_output_vc_arbiter.sv
// Bench for exa_crosb_output_vc_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a packet-level model of grants and credits.
module tb_exa_crosb_output_vc_arbiter;
    localparam int N = 4, P = 2, V = 2, NV = 4, CR = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N*NV-1:0] i_request = '0;
    logic [N-1:0]  i_valid = '0, i_last = '0;
    logic [NV-1:0] i_credit_return = '0;
    logic [N-1:0]  o_grant;
    logic [1:0]    o_grant_vc, o_write_vc;
    logic          o_ready, o_write_en, o_credit_err;
    logic [NV-1:0] o_credits;

    int checks = 0, fails = 0;
    int pkt_vc[N], pkt_rem[N];
    int vprob = 100, noise = 0;

    int m_cnt[NV], m_vptr[P];
    int m_g = 0, m_k = 0, m_iptr = 0;
    bit m_busy = 0, m_err = 0;
    logic [N-1:0]  exp_grant;
    logic          exp_ready, exp_we, exp_err;
    logic [NV-1:0] exp_cred;

    exa_crosb_output_vc_arbiter dut (
        .clk(clk), .reset(reset), .i_request(i_request), .i_valid(i_valid), .i_last(i_last),
        .i_credit_return(i_credit_return), .o_grant(o_grant), .o_grant_vc(o_grant_vc),
        .o_ready(o_ready), .o_write_en(o_write_en), .o_write_vc(o_write_vc),
        .o_credits(o_credits), .o_credit_err(o_credit_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    task automatic model_reset();
        for (int k = 0; k < NV; k++) m_cnt[k] = CR;
        for (int p = 0; p < P; p++) m_vptr[p] = 0;
        for (int i = 0; i < N; i++) begin pkt_vc[i] = -1; pkt_rem[i] = 0; end
        m_busy = 0; m_err = 0; m_iptr = 0; m_g = 0; m_k = 0;
        i_credit_return = '0;
    endtask

    function automatic bit requested(int k);
        for (int i = 0; i < N; i++) if (i_request[i*NV + k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            i_request[i*NV +: NV] = (pkt_vc[i] >= 0) ? NV'(1 << pkt_vc[i]) : '0;
            if (pkt_vc[i] >= 0) i_valid[i] = ($urandom_range(99) < vprob);
            else                i_valid[i] = ($urandom_range(99) < noise);
            i_last[i] = i_valid[i] && (pkt_vc[i] < 0 || pkt_rem[i] == 1);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        exp_grant = m_busy ? N'(1 << m_g) : '0;
        exp_ready = m_busy && (m_cnt[m_k] > 0);
        exp_we    = exp_ready && i_valid[m_g];
        exp_err   = m_err;
        for (int k = 0; k < NV; k++) exp_cred[k] = (m_cnt[k] > 0);
    endtask

    // Model transition for the cycle just sampled, then move to just after the next edge.
    task automatic advance();
        int g0, k0, best_k, best_i, bd, d;
        g0 = m_g; k0 = m_k;
        if (!m_busy) begin
            best_k = -1;
            for (int p = P - 1; p >= 0; p--) begin
                if (best_k < 0) begin
                    bd = V;
                    for (int v = 0; v < V; v++) begin
                        d = (v - m_vptr[p] - 1 + 2*V) % V;
                        if (m_cnt[p*V+v] > 0 && requested(p*V+v) && d < bd) begin bd = d; best_k = p*V+v; end
                    end
                end
            end
            if (best_k >= 0) begin
                bd = N; best_i = 0;
                for (int i = 0; i < N; i++) begin
                    d = (i - m_iptr - 1 + 2*N) % N;
                    if (i_request[i*NV + best_k] && d < bd) begin bd = d; best_i = i; end
                end
                m_busy = 1; m_g = best_i; m_k = best_k;
            end
        end else if (exp_we && i_last[g0]) begin
            m_busy = 0; m_iptr = g0; m_vptr[k0 / V] = k0 % V;
        end
        if (exp_we) begin
            pkt_rem[g0]--;
            if (pkt_rem[g0] == 0) pkt_vc[g0] = -1;
        end
        for (int k = 0; k < NV; k++) begin
            if (exp_we && k == k0 && !i_credit_return[k]) m_cnt[k]--;
            else if (!(exp_we && k == k0) && i_credit_return[k]) begin
                if (m_cnt[k] == CR) m_err = 1; else m_cnt[k]++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_request = '0; i_valid = '0; i_last = '0;
        model_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (o_grant !== 4'b0000) begin fails++; $display("FAIL reset_grant got=%b want=0000", o_grant); end
        if (o_grant_vc !== 2'd0) begin fails++; $display("FAIL reset_grant_vc got=%0d want=0", o_grant_vc); end
        if (o_write_en !== 1'b0) begin fails++; $display("FAIL reset_write_en got=%b want=0", o_write_en); end
        if (o_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b want=0", o_ready); end
        if (o_credits !== 4'b1111) begin fails++; $display("FAIL reset_credits got=%b want=1111", o_credits); end
        if (o_credit_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", o_credit_err); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_packet();
        int first, wes;
        first = -1; wes = 0;
        pkt_vc[1] = 2; pkt_rem[1] = 3;
        for (int c = 0; c < 6; c++) begin
            drive(); sample();
            checks += 5;
            if (o_grant !== exp_grant) begin fails++; $display("FAIL single grant c=%0d got=%b want=%b", c, o_grant, exp_grant); end
            if (o_ready !== exp_ready) begin fails++; $display("FAIL single ready c=%0d got=%b want=%b", c, o_ready, exp_ready); end
            if (o_write_en !== exp_we) begin fails++; $display("FAIL single write_en c=%0d got=%b want=%b", c, o_write_en, exp_we); end
            if (o_credits !== exp_cred) begin fails++; $display("FAIL single credits c=%0d got=%b want=%b", c, o_credits, exp_cred); end
            if (o_credit_err !== exp_err) begin fails++; $display("FAIL single err c=%0d got=%b want=%b", c, o_credit_err, exp_err); end
            if (exp_grant != '0) begin
                checks++;
                if (o_grant_vc !== 2'd2 || o_write_vc !== 2'd2) begin fails++; $display("FAIL single vc c=%0d got=%0d/%0d want=2", c, o_grant_vc, o_write_vc); end
            end
            if (o_grant != '0 && first < 0) first = c;
            if (o_write_en === 1'b1) wes++;
            advance();
        end
        checks += 2;
        if (first != 1) begin fails++; $display("FAIL single grant_latency got=%0d want=1", first); end
        if (wes != 3) begin fails++; $display("FAIL single write_count got=%0d want=3", wes); end
    endtask

    task automatic test_prio_round_robin();
        logic [N-1:0] seq[$];
        logic [N-1:0] want[3];
        logic [N-1:0] prev;
        int lowrun;
        bit seen;
        // Input 2's packet leaves the input pointer on 2, so input 3 is next in line before input 0.
        want = '{4'b0100, 4'b1000, 4'b0001};
        prev = '0; lowrun = 0; seen = 0;
        pkt_vc[0] = 0; pkt_rem[0] = 2;
        pkt_vc[3] = 0; pkt_rem[3] = 2;
        pkt_vc[2] = 3; pkt_rem[2] = 2;
        for (int c = 0; c < 11; c++) begin
            drive(); sample();
            checks += 4;
            if (o_grant !== exp_grant) begin fails++; $display("FAIL prio grant c=%0d got=%b want=%b", c, o_grant, exp_grant); end
            if (o_ready !== exp_ready) begin fails++; $display("FAIL prio ready c=%0d got=%b want=%b", c, o_ready, exp_ready); end
            if (o_write_en !== exp_we) begin fails++; $display("FAIL prio write_en c=%0d got=%b want=%b", c, o_write_en, exp_we); end
            if (o_credits !== exp_cred) begin fails++; $display("FAIL prio credits c=%0d got=%b want=%b", c, o_credits, exp_cred); end
            if (exp_grant != '0) begin
                checks++;
                if (o_grant_vc !== 2'(m_k)) begin fails++; $display("FAIL prio grant_vc c=%0d got=%0d want=%0d", c, o_grant_vc, m_k); end
            end
            if (o_grant != '0 && prev == '0) begin
                seq.push_back(o_grant);
                if (seen) begin
                    checks++;
                    if (lowrun != 1) begin fails++; $display("FAIL prio gap c=%0d got=%0d want=1", c, lowrun); end
                end
                seen = 1;
            end
            if (o_grant == '0) lowrun++; else lowrun = 0;
            prev = o_grant;
            advance();
        end
        checks++;
        if (seq.size() != 3) begin fails++; $display("FAIL prio grant_count got=%0d want=3", seq.size()); end
        for (int i = 0; i < seq.size() && i < 3; i++) begin
            checks++;
            if (seq[i] !== want[i]) begin fails++; $display("FAIL prio order idx=%0d got=%b want=%b", i, seq[i], want[i]); end
        end
    endtask

    task automatic test_credit_stall();
        int wes;
        wes = 0;
        pkt_vc[0] = 1; pkt_rem[0] = 10;
        for (int c = 0; c < 19; c++) begin
            drive();
            i_credit_return = (c == 14 || c == 15) ? 4'b0010 : 4'b0000;
            sample();
            checks += 4;
            if (o_grant !== exp_grant) begin fails++; $display("FAIL stall grant c=%0d got=%b want=%b", c, o_grant, exp_grant); end
            if (o_ready !== exp_ready) begin fails++; $display("FAIL stall ready c=%0d got=%b want=%b", c, o_ready, exp_ready); end
            if (o_write_en !== exp_we) begin fails++; $display("FAIL stall write_en c=%0d got=%b want=%b", c, o_write_en, exp_we); end
            if (o_credits !== exp_cred) begin fails++; $display("FAIL stall credits c=%0d got=%b want=%b", c, o_credits, exp_cred); end
            if (o_write_en === 1'b1) wes++;
            if (c == 12) begin
                checks += 3;
                if (o_ready !== 1'b0) begin fails++; $display("FAIL stall ready_low got=%b want=0", o_ready); end
                if (o_credits[1] !== 1'b0) begin fails++; $display("FAIL stall credit_bit got=%b want=0", o_credits[1]); end
                if (wes != 8) begin fails++; $display("FAIL stall writes_before_stall got=%0d want=8", wes); end
            end
            if (c == 18) begin
                checks += 2;
                if (wes != 10) begin fails++; $display("FAIL stall total_writes got=%0d want=10", wes); end
                if (o_grant !== 4'b0000) begin fails++; $display("FAIL stall release got=%b want=0000", o_grant); end
            end
            advance();
        end
    endtask

    task automatic test_credit_return_err();
        do_reset();
        pkt_vc[1] = 0; pkt_rem[1] = 3;
        for (int c = 0; c < 13; c++) begin
            if (c == 4) begin pkt_vc[2] = 0; pkt_rem[2] = 1; end
            drive();
            i_credit_return = (c >= 5 && c <= 9) ? 4'b0001 : 4'b0000;
            sample();
            checks += 5;
            if (o_grant !== exp_grant) begin fails++; $display("FAIL cerr grant c=%0d got=%b want=%b", c, o_grant, exp_grant); end
            if (o_ready !== exp_ready) begin fails++; $display("FAIL cerr ready c=%0d got=%b want=%b", c, o_ready, exp_ready); end
            if (o_write_en !== exp_we) begin fails++; $display("FAIL cerr write_en c=%0d got=%b want=%b", c, o_write_en, exp_we); end
            if (o_credits !== exp_cred) begin fails++; $display("FAIL cerr credits c=%0d got=%b want=%b", c, o_credits, exp_cred); end
            if (o_credit_err !== exp_err) begin fails++; $display("FAIL cerr err c=%0d got=%b want=%b", c, o_credit_err, exp_err); end
            if (c == 9) begin
                checks++;
                if (o_credit_err !== 1'b0) begin fails++; $display("FAIL cerr early_err got=%b want=0", o_credit_err); end
            end
            if (c >= 10) begin
                checks++;
                if (o_credit_err !== 1'b1) begin fails++; $display("FAIL cerr sticky c=%0d got=%b want=1", c, o_credit_err); end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_packet();
        pkt_vc[2] = 1; pkt_rem[2] = 5;
        for (int c = 0; c < 3; c++) begin drive(); sample(); advance(); end
        reset = 1'b1;
        #2;
        checks += 4;
        if (o_grant !== 4'b0000) begin fails++; $display("FAIL rstmid grant got=%b want=0000", o_grant); end
        if (o_credits !== 4'b1111) begin fails++; $display("FAIL rstmid credits got=%b want=1111", o_credits); end
        if (o_ready !== 1'b0) begin fails++; $display("FAIL rstmid ready got=%b want=0", o_ready); end
        if (o_write_en !== 1'b0) begin fails++; $display("FAIL rstmid write_en got=%b want=0", o_write_en); end
        model_reset();
        i_request = '0; i_valid = '0; i_last = '0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        pkt_vc[1] = 0; pkt_rem[1] = 1;
        pkt_vc[3] = 0; pkt_rem[3] = 1;
        for (int c = 0; c < 5; c++) begin
            drive(); sample();
            checks += 4;
            if (o_grant !== exp_grant) begin fails++; $display("FAIL rstmid grant c=%0d got=%b want=%b", c, o_grant, exp_grant); end
            if (o_write_en !== exp_we) begin fails++; $display("FAIL rstmid write_en c=%0d got=%b want=%b", c, o_write_en, exp_we); end
            if (o_credits !== exp_cred) begin fails++; $display("FAIL rstmid credits c=%0d got=%b want=%b", c, o_credits, exp_cred); end
            if (o_credit_err !== exp_err) begin fails++; $display("FAIL rstmid err c=%0d got=%b want=%b", c, o_credit_err, exp_err); end
            if (c == 1) begin
                checks++;
                if (o_grant !== 4'b0010) begin fails++; $display("FAIL rstmid first_grant got=%b want=0010", o_grant); end
            end
            advance();
        end
    endtask

    task automatic test_blocked_vc();
        int first0;
        first0 = -1;
        pkt_vc[3] = 3; pkt_rem[3] = 8;
        for (int c = 0; c < 22; c++) begin
            if (c == 9) begin
                pkt_vc[0] = 3; pkt_rem[0] = 1;
                pkt_vc[1] = 0; pkt_rem[1] = 2;
            end
            drive();
            i_credit_return = (c == 16) ? 4'b1000 : 4'b0000;
            sample();
            checks += 4;
            if (o_grant !== exp_grant) begin fails++; $display("FAIL blocked grant c=%0d got=%b want=%b", c, o_grant, exp_grant); end
            if (o_ready !== exp_ready) begin fails++; $display("FAIL blocked ready c=%0d got=%b want=%b", c, o_ready, exp_ready); end
            if (o_write_en !== exp_we) begin fails++; $display("FAIL blocked write_en c=%0d got=%b want=%b", c, o_write_en, exp_we); end
            if (o_credits !== exp_cred) begin fails++; $display("FAIL blocked credits c=%0d got=%b want=%b", c, o_credits, exp_cred); end
            if (c == 10) begin
                checks++;
                if (o_grant !== 4'b0010) begin fails++; $display("FAIL blocked input1_first got=%b want=0010", o_grant); end
            end
            if (o_grant[0] === 1'b1 && first0 < 0) first0 = c;
            advance();
        end
        checks++;
        if (first0 != 18) begin fails++; $display("FAIL blocked input0_grant_cycle got=%0d want=18", first0); end
    endtask

    task automatic test_random();
        do_reset();
        vprob = 70; noise = 30;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pkt_vc[i] < 0 && $urandom_range(99) < 20) begin
                    pkt_vc[i]  = int'($urandom_range(NV-1));
                    pkt_rem[i] = int'($urandom_range(5, 1));
                end
            end
            drive();
            for (int k = 0; k < NV; k++) begin
                if (m_cnt[k] < CR) i_credit_return[k] = ($urandom_range(99) < 35);
                else               i_credit_return[k] = ($urandom_range(199) == 0);
            end
            sample();
            checks += 5;
            if (o_grant !== exp_grant) begin fails++; $display("FAIL random grant c=%0d got=%b want=%b", c, o_grant, exp_grant); end
            if (o_ready !== exp_ready) begin fails++; $display("FAIL random ready c=%0d got=%b want=%b", c, o_ready, exp_ready); end
            if (o_write_en !== exp_we) begin fails++; $display("FAIL random write_en c=%0d got=%b want=%b", c, o_write_en, exp_we); end
            if (o_credits !== exp_cred) begin fails++; $display("FAIL random credits c=%0d got=%b want=%b", c, o_credits, exp_cred); end
            if (o_credit_err !== exp_err) begin fails++; $display("FAIL random err c=%0d got=%b want=%b", c, o_credit_err, exp_err); end
            if (exp_grant != '0) begin
                checks++;
                if (o_grant_vc !== 2'(m_k) || o_write_vc !== 2'(m_k)) begin fails++; $display("FAIL random vc c=%0d got=%0d/%0d want=%0d", c, o_grant_vc, o_write_vc, m_k); end
            end
            advance();
        end
        vprob = 100; noise = 0;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_prio_round_robin();
        test_credit_stall();
        test_credit_return_err();
        test_reset_mid_packet();
        test_blocked_vc();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
